ctrl_pc_ras: RTL and testbench
==============================

# ctrl_pc_ras

Parameterised program counter with an integrated hardware return-address stack (RAS) for the 8-bit RISC-RNS core. It sits in the control path ahead of instruction fetch and supplies the fetch address every cycle. Redirects from EX (branch, call, return) are taken at the store-result stage. A stall input holds the sequential stream.

## Interface
Parameters:
- PROG_CTR_WID, 10, PC width in bits (≥2)
- RAS_DEPTH, 4, return-stack entries (power of two, ≥2)
- RESET_VEC, 0, PC value after reset (PROG_CTR_WID bits)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC (sequential advance only)
- branch_taken_EX  in  1  redirect to nxt_prog_ctr_EX
- call_EX  in  1  redirect to nxt_prog_ctr_EX and push link_addr_EX
- ret_EX  in  1  redirect to popped RAS top
- nxt_prog_ctr_EX  in  PROG_CTR_WID  branch/call target
- link_addr_EX  in  PROG_CTR_WID  return address pushed on call
- prog_ctr  out  PROG_CTR_WID  current fetch address, registered
- ras_count  out  $clog2(RAS_DEPTH+1)  valid entries
- ras_full  out  1  ras_count == RAS_DEPTH
- ras_empty  out  1  ras_count == 0
- ras_ovf  out  1  sticky, push while full occurred
- ras_udf  out  1  sticky, pop while empty occurred

## Operation
- Per-edge priority: reset > ret_EX > call_EX > branch_taken_EX > stall > increment.
- reset: prog_ctr=RESET_VEC, ras_count=0, ras_ovf=ras_udf=0, stack contents don't-care.
- ret_EX, stack non-empty: prog_ctr ← top, count−1.
- ret_EX, stack empty: prog_ctr ← nxt_prog_ctr_EX (fallback). Set ras_udf. Count stays 0.
- ret_EX and call_EX together (tail call): prog_ctr ← old top. Top entry overwritten with link_addr_EX. Count unchanged. If empty: prog_ctr ← nxt_prog_ctr_EX, push link_addr_EX (count=1), set ras_udf.
- call_EX, not full: prog_ctr ← nxt_prog_ctr_EX, push link_addr_EX, count+1.
- call_EX, full: oldest entry discarded (circular), link pushed, count stays RAS_DEPTH, set ras_ovf.
- branch_taken_EX: prog_ctr ← nxt_prog_ctr_EX. Stack untouched. branch_taken_EX with call/ret is redundant and ignored.
- Redirects ignore stall. Stall blocks only the +1 advance.
- Increment: prog_ctr+1 modulo 2^PROG_CTR_WID, so all-ones wraps to 0 with no flag.
- Sticky flags clear only on reset.

## Timing
- All outputs registered. An event sampled at edge N is visible after edge N; latency is 1 cycle.
- ras_full/ras_empty are derived from the registered count. No combinational path from inputs to outputs.
- Back-to-back call/ret on consecutive cycles must be supported at full rate. A ret in cycle N+1 pops the entry pushed in cycle N.
- Reset mid-sequence (e.g. during a call) discards the push. After reset the PC is RESET_VEC regardless of other inputs.

## Structure
- Shared package ctrl_pkg:
  - RAS op encoding typedef (NONE, PUSH, POP, SWAP).
  - Default RESET_VEC constant.
- Sub-module ctrl_ras_stack:
  - Circular buffer with top pointer and count.
  - Takes an op and returns top, full, empty, ovf/udf pulses.
- ctrl_pc_ras holds the PC register, priority decode and sticky flags.

## Test plan
- Reset with RESET_VEC=0x010, then 3 idle cycles → prog_ctr 0x010, 0x011, 0x012, 0x013; ras_empty=1.
- Run from 0x3FE (PROG_CTR_WID=10), then stall for 2 cycles with branch to 0x100 in the 2nd → 0x3FF, 0x000, 0x000 held, then 0x100.
- Five calls, link 0x001..0x005 (RAS_DEPTH=4), then five rets (fallback target 0x2AA):
  - Returns 0x005, 0x004, 0x003, 0x002, then 0x2AA.
  - ras_ovf=1 after the 5th call; ras_udf=1 after the 5th ret.
- Call (link 0x050), next cycle call+ret together (link 0x070) → PC=0x050, count=1; then ret → PC=0x070, count=0.
- Reset asserted in the same cycle as call_EX → prog_ctr=RESET_VEC, count=0, flags=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_pkg : shared RAS operation encoding and control-path defaults       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package ctrl_pkg;

    typedef enum logic [1:0] {
        RAS_NONE = 2'd0,
        RAS_PUSH = 2'd1,
        RAS_POP  = 2'd2,
        RAS_SWAP = 2'd3
    } ras_op_e;

    localparam int unsigned DEF_RESET_VEC = 0;

endpackage
`default_nettype wire

// File: rtl/ctrl_pc_ras_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_pc_ras_if : EX redirect inputs and PC/RAS status outputs            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface ctrl_pc_ras_if #(
    parameter int unsigned PROG_CTR_WID = 10,
    parameter int unsigned RAS_DEPTH    = 4
) ();

    logic                             stall;
    logic                             branch_taken_EX;
    logic                             call_EX;
    logic                             ret_EX;
    logic [PROG_CTR_WID-1:0]          nxt_prog_ctr_EX;
    logic [PROG_CTR_WID-1:0]          link_addr_EX;

    logic [PROG_CTR_WID-1:0]          prog_ctr;
    logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count;
    logic                             ras_full;
    logic                             ras_empty;
    logic                             ras_ovf;
    logic                             ras_udf;

    modport master (
        output stall, branch_taken_EX, call_EX, ret_EX, nxt_prog_ctr_EX, link_addr_EX,
        input  prog_ctr, ras_count, ras_full, ras_empty, ras_ovf, ras_udf
    );

    modport slave (
        input  stall, branch_taken_EX, call_EX, ret_EX, nxt_prog_ctr_EX, link_addr_EX,
        output prog_ctr, ras_count, ras_full, ras_empty, ras_ovf, ras_udf
    );

endinterface
`default_nettype wire

// File: rtl/ctrl_ras_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_ras_stack : circular return-address stack with top pointer/count    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module ctrl_ras_stack
    import ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  wire logic                         clk,
    input  wire logic                         reset,
    input  ras_op_e                           op_i,
    input  wire logic [WIDTH-1:0]             push_data_i,
    output logic      [WIDTH-1:0]             top_o,
    output logic      [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                              full_o,
    output logic                              empty_o,
    output logic                              ovf_o,
    output logic                              udf_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign top_o   = mem_q[ptr_q];

    // A push while full simply advances the pointer, overwriting the oldest slot.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_addr = ptr_q + 1'b1;
        ovf_o   = 1'b0;
        udf_o   = 1'b0;
        case (op_i)
            RAS_PUSH: begin
                wr_en = 1'b1;
                ptr_d = ptr_q + 1'b1;
                if (full_o) begin
                    ovf_o = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            RAS_POP: begin
                if (empty_o) begin
                    udf_o = 1'b1;
                end else begin
                    ptr_d   = ptr_q - 1'b1;
                    count_d = count_q - 1'b1;
                end
            end
            RAS_SWAP: begin
                wr_en = 1'b1;
                if (empty_o) begin
                    udf_o   = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    count_d = CNT_W'(1);
                end else begin
                    wr_addr = ptr_q;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_addr] <= push_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_pc_ras.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_pc_ras : fetch PC register with EX redirect priority and RAS        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module ctrl_pc_ras
    import ctrl_pkg::*;
#(
    parameter int unsigned PROG_CTR_WID = 10,
    parameter int unsigned RAS_DEPTH    = 4,
    parameter int unsigned RESET_VEC    = DEF_RESET_VEC
) (
    input  wire logic       clk,
    input  wire logic       reset,
    ctrl_pc_ras_if.slave    bus
);

    localparam int unsigned              CNT_W      = $clog2(RAS_DEPTH+1);
    localparam logic [PROG_CTR_WID-1:0]  C_RESET_PC = PROG_CTR_WID'(RESET_VEC);

    logic [PROG_CTR_WID-1:0] pc_q, pc_d;
    logic                    ovf_q, udf_q;
    ras_op_e                 ras_op;
    logic [PROG_CTR_WID-1:0] ras_top;
    logic [CNT_W-1:0]        ras_count;
    logic                    ras_full, ras_empty;
    logic                    ras_ovf_pulse, ras_udf_pulse;

    ctrl_ras_stack #(
        .WIDTH (PROG_CTR_WID),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .op_i        (ras_op),
        .push_data_i (bus.link_addr_EX),
        .top_o       (ras_top),
        .count_o     (ras_count),
        .full_o      (ras_full),
        .empty_o     (ras_empty),
        .ovf_o       (ras_ovf_pulse),
        .udf_o       (ras_udf_pulse)
    );

    // ret outranks call; both together is a tail call that swaps the top entry.
    always_comb begin
        ras_op = RAS_NONE;
        pc_d   = pc_q;
        if (bus.ret_EX) begin
            ras_op = bus.call_EX ? RAS_SWAP : RAS_POP;
            pc_d   = ras_empty ? bus.nxt_prog_ctr_EX : ras_top;
        end else if (bus.call_EX) begin
            ras_op = RAS_PUSH;
            pc_d   = bus.nxt_prog_ctr_EX;
        end else if (bus.branch_taken_EX) begin
            pc_d   = bus.nxt_prog_ctr_EX;
        end else if (!bus.stall) begin
            pc_d   = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= C_RESET_PC;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_q | ras_ovf_pulse;
            udf_q <= udf_q | ras_udf_pulse;
        end
    end

    assign bus.prog_ctr  = pc_q;
    assign bus.ras_count = ras_count;
    assign bus.ras_full  = ras_full;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_udf   = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pc_ras.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ctrl_pc_ras : scoreboard bench with a queue-based return-stack model  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_ctrl_pc_ras;

    localparam int unsigned W  = 10;
    localparam int unsigned D  = 4;
    localparam int unsigned RV = 16;

    typedef struct {
        logic [W-1:0] pc;
        int           cnt;
        logic         full;
        logic         empty;
        logic         ovf;
        logic         udf;
        string        tag;
    } exp_t;

    logic clk;
    logic reset;

    ctrl_pc_ras_if #(.PROG_CTR_WID(W), .RAS_DEPTH(D)) bus ();

    ctrl_pc_ras #(
        .PROG_CTR_WID (W),
        .RAS_DEPTH    (D),
        .RESET_VEC    (RV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t         exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;

    logic [W-1:0] m_pc;
    logic [W-1:0] m_ras[$];
    logic         m_ovf;
    logic         m_udf;

    // Drive one cycle of stimulus and queue the state expected after the next edge.
    task automatic step(input logic rst, input logic st, input logic br, input logic ca,
                        input logic re, input logic [W-1:0] nxt, input logic [W-1:0] lnk,
                        input string tag);
        exp_t e;
        @(negedge clk);
        reset               = rst;
        bus.stall           = st;
        bus.branch_taken_EX = br;
        bus.call_EX         = ca;
        bus.ret_EX          = re;
        bus.nxt_prog_ctr_EX = nxt;
        bus.link_addr_EX    = lnk;
        if (rst) begin
            m_pc  = W'(RV);
            m_ras.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (re) begin
            if (m_ras.size() == 0) begin
                m_pc  = nxt;
                m_udf = 1'b1;
                if (ca) m_ras.push_back(lnk);
            end else begin
                m_pc = m_ras[m_ras.size()-1];
                if (ca) m_ras[m_ras.size()-1] = lnk;
                else    void'(m_ras.pop_back());
            end
        end else if (ca) begin
            m_pc = nxt;
            if (m_ras.size() == D) begin
                void'(m_ras.pop_front());
                m_ovf = 1'b1;
            end
            m_ras.push_back(lnk);
        end else if (br) begin
            m_pc = nxt;
        end else if (!st) begin
            m_pc = m_pc + 1'b1;
        end
        e.pc    = m_pc;
        e.cnt   = m_ras.size();
        e.full  = (m_ras.size() == D);
        e.empty = (m_ras.size() == 0);
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, tag);
    endtask

    // Monitor: the DUT presents a new state after every edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (bus.prog_ctr !== e.pc || int'(bus.ras_count) != e.cnt ||
                    bus.ras_full !== e.full || bus.ras_empty !== e.empty ||
                    bus.ras_ovf !== e.ovf || bus.ras_udf !== e.udf) begin
                    n_err++;
                    $display("FAIL %s vec %0d: got pc=%h cnt=%0d full=%b empty=%b ovf=%b udf=%b, want pc=%h cnt=%0d full=%b empty=%b ovf=%b udf=%b",
                             e.tag, n_vec, bus.prog_ctr, bus.ras_count, bus.ras_full,
                             bus.ras_empty, bus.ras_ovf, bus.ras_udf,
                             e.pc, e.cnt, e.full, e.empty, e.ovf, e.udf);
                end
            end
        end
    end

    initial begin : driver
        int r;
        logic rs, st, br, ca, re;
        reset               = 1'b1;
        bus.stall           = 1'b0;
        bus.branch_taken_EX = 1'b0;
        bus.call_EX         = 1'b0;
        bus.ret_EX          = 1'b0;
        bus.nxt_prog_ctr_EX = '0;
        bus.link_addr_EX    = '0;
        m_pc  = W'(RV);
        m_ovf = 1'b0;
        m_udf = 1'b0;

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, "reset");
        for (int i = 0; i < 3; i++) idle("idle_inc");

        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h3FE, '0, "branch_3fe");
        idle("inc_3ff");
        idle("wrap_000");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, "stall_hold");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h100, '0, "stall_branch");

        for (int i = 1; i <= 5; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(10'h200 + i), W'(i), "call_seq");
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h2AA, '0, "ret_seq");

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, "reset2");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h300, 10'h050, "call_050");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h310, 10'h070, "tail_call");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h2AA, '0, "ret_070");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h123, 10'h0AB, "tail_empty");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h2AA, '0, "ret_0ab");

        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h140, 10'h041, "call_pre");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h150, 10'h051, "reset_call");
        idle("post_reset");

        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 99);
            rs = (r < 2);
            st = ($urandom_range(0, 99) < 30);
            br = ($urandom_range(0, 99) < 20);
            ca = ($urandom_range(0, 99) < 25);
            re = ($urandom_range(0, 99) < 25);
            step(rs, st, br, ca, re, W'($urandom), W'($urandom), "random");
        end

        idle("drain");
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
